// File: rtl/ipml_wr_pack_pkg.sv
// Shared sizing helpers for the write-side packer and its output skid buffer.
package ipml_wr_pack_pkg;

   // Lane index width, never narrower than one bit even when R = 1.
   function automatic int lane_idx_w(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

   // Skid-buffer entry layout: {last, keep[R-1:0], data[DW-1:0]}.
   function automatic int entry_w(input int dw, input int r);
      return dw + r + 1;
   endfunction

endpackage

// File: rtl/ipml_wr_skid2.sv
// Two-entry register FIFO between the lane packer and the FIFO write port.
// The full flag is registered so the upstream ready never sees wr_vld combinationally.
module ipml_wr_skid2 #(
   parameter int EW = 37
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [EW-1:0] entry_i,
   input  logic          rdy_i,
   output logic [EW-1:0] head_o,
   output logic          pop_o,
   output logic          full_o
);

   logic [1:0]    cnt_q, cnt_d;
   logic [EW-1:0] ent0_q, ent0_d;
   logic [EW-1:0] ent1_q, ent1_d;
   logic          full_q, full_d;
   logic          pop;

   always_comb begin
      pop    = (cnt_q != 2'd0) & rdy_i;
      cnt_d  = cnt_q;
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      case ({push_i, pop})
         2'b10: begin
            if (cnt_q == 2'd0) ent0_d = entry_i;
            else               ent1_d = entry_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            ent1_d = '0;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = entry_i;
            end else begin
               ent0_d = ent1_q;
               ent1_d = entry_i;
            end
         end
         default: ;
      endcase
      full_d = (cnt_d == 2'd2);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= 2'd0;
         ent0_q <= '0;
         ent1_q <= '0;
         full_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         full_q <= full_d;
      end
   end

   // A popped-to-empty head keeps stale contents, so mask it here.
   assign head_o = (cnt_q != 2'd0) ? ent0_q : '0;
   assign pop_o  = pop;
   assign full_o = full_q;

endmodule

// File: rtl/ipml_wr_pack_v1_0.sv
// Packs a byte-serial framed stream into wide FIFO words with lane-keep and last flags.
// Accumulator, lane counter and keep builder live here; buffering is in ipml_wr_skid2.
module ipml_wr_pack_v1_0
   import ipml_wr_pack_pkg::*;
#(
   parameter int c_IN_WIDTH      = 8,
   parameter int c_WR_DATA_WIDTH = 32
) (
   input  logic                                  wr_clk,
   input  logic                                  wr_rst,
   input  logic [c_IN_WIDTH-1:0]                 s_data,
   input  logic                                  s_valid,
   input  logic                                  s_last,
   output logic                                  s_ready,
   output logic [c_WR_DATA_WIDTH-1:0]            wr_data,
   output logic [c_WR_DATA_WIDTH/c_IN_WIDTH-1:0] wr_keep,
   output logic                                  wr_last,
   output logic                                  wr_en,
   input  logic                                  wr_vld,
   output logic [15:0]                           frame_cnt
);

   localparam int R  = c_WR_DATA_WIDTH / c_IN_WIDTH;
   localparam int LW = lane_idx_w(R);
   localparam int EW = entry_w(c_WR_DATA_WIDTH, R);
   localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);

   logic [LW-1:0]              lane_cnt_q, lane_cnt_d;
   logic [c_WR_DATA_WIDTH-1:0] acc_q, acc_d;
   logic [15:0]                frame_cnt_q;
   logic [c_WR_DATA_WIDTH-1:0] word;
   logic [R-1:0]               keep;
   logic                       accept, word_done, full;
   logic [EW-1:0]              head;

   always_comb begin
      accept     = s_valid & s_ready;
      word_done  = accept & (s_last | (lane_cnt_q == LAST_LANE));
      word       = acc_q;
      keep       = '0;
      lane_cnt_d = lane_cnt_q;
      acc_d      = acc_q;
      for (int i = 0; i < R; i++) begin
         if (lane_cnt_q == LW'(i)) word[i*c_IN_WIDTH +: c_IN_WIDTH] = s_data;
         keep[i] = (LW'(i) <= lane_cnt_q);
      end
      if (accept) begin
         if (word_done) begin
            lane_cnt_d = '0;
            acc_d      = '0;
         end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
            acc_d      = word;
         end
      end
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         lane_cnt_q  <= '0;
         acc_q       <= '0;
         frame_cnt_q <= 16'd0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         acc_q      <= acc_d;
         if (wr_en & wr_last) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   ipml_wr_skid2 #(.EW(EW)) u_skid (
      .clk_i   (wr_clk),
      .rst_i   (wr_rst),
      .push_i  (word_done),
      .entry_i ({s_last, keep, word}),
      .rdy_i   (wr_vld),
      .head_o  (head),
      .pop_o   (wr_en),
      .full_o  (full)
   );

   assign {wr_last, wr_keep, wr_data} = head;
   assign s_ready   = ~full & ~wr_rst;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ipml_wr_pack_v1_0.sv
// Scoreboard bench for ipml_wr_pack_v1_0 (8-bit lanes into 32-bit words).
module tb_ipml_wr_pack_v1_0;

   logic        wr_clk = 1'b0;
   logic        wr_rst = 1'b1;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_keep;
   logic        wr_last;
   logic        wr_en;
   logic        wr_vld = 1'b1;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int stalls = 0;
   int w0;
   logic [36:0] exp_q[$];

   ipml_wr_pack_v1_0 #(.c_IN_WIDTH(8), .c_WR_DATA_WIDTH(32)) dut (
      .wr_clk    (wr_clk),
      .wr_rst    (wr_rst),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .wr_data   (wr_data),
      .wr_keep   (wr_keep),
      .wr_last   (wr_last),
      .wr_en     (wr_en),
      .wr_vld    (wr_vld),
      .frame_cnt (frame_cnt)
   );

   always #5 wr_clk = ~wr_clk;

   task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic last, input logic [3:0] keep, input logic [31:0] data);
      exp_q.push_back({last, keep, data});
   endtask

   always @(negedge wr_clk) begin
      if (!wr_rst && wr_en) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got %h want none", {wr_last, wr_keep, wr_data});
         end else begin
            chk("wr_word", {wr_last, wr_keep, wr_data}, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic last);
      logic rdy;
      int n;
      n = 0;
      s_data  = d;
      s_last  = last;
      s_valid = 1'b1;
      do begin
         @(negedge wr_clk);
         rdy = s_ready;
         if (!rdy) stalls++;
         n++;
         @(posedge wr_clk);
         #1;
      end while (!rdy && n < 1000);
      if (!rdy) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got ready=0 want ready=1 for lane %h", d);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge wr_clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
      @(posedge wr_clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #12;
      chk("rst_s_ready", 37'(s_ready), 37'd0);
      chk("rst_wr_en", 37'(wr_en), 37'd0);
      chk("rst_head", {wr_last, wr_keep, wr_data}, 37'd0);
      chk("rst_frame_cnt", 37'(frame_cnt), 37'd0);
      @(posedge wr_clk); #1;
      wr_rst = 1'b0;
      @(negedge wr_clk);
      chk("ready_after_rst", 37'(s_ready), 37'd1);
      @(posedge wr_clk); #1;

      // two full words, frame of 8
      stalls = 0;
      push_exp(1'b0, 4'b1111, 32'h04030201);
      push_exp(1'b1, 4'b1111, 32'h08070605);
      for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
      drain();
      chk("frame_cnt_1", 37'(frame_cnt), 37'd1);

      // 5-lane frame, partial tail
      push_exp(1'b0, 4'b1111, 32'hA3A2A1A0);
      push_exp(1'b1, 4'b0001, 32'h000000A4);
      for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 4);
      drain();
      chk("frame_cnt_2", 37'(frame_cnt), 37'd2);

      // single lane, one-cycle latency
      push_exp(1'b1, 4'b0001, 32'h00000055);
      send(8'h55, 1'b1);
      @(negedge wr_clk);
      chk("latency_wr_en", 37'(wr_en), 37'd1);
      drain();
      chk("frame_cnt_3", 37'(frame_cnt), 37'd3);
      chk("no_stall_vld_high", 37'(stalls), 37'd0);

      // back-pressure: 12 lanes with wr_vld low
      wr_vld = 1'b0;
      stalls = 0;
      push_exp(1'b0, 4'b1111, 32'h24232221);
      push_exp(1'b0, 4'b1111, 32'h28272625);
      push_exp(1'b1, 4'b1111, 32'h2C2B2A29);
      w0 = wr_cnt;
      for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), 1'b0);
      repeat (3) @(negedge wr_clk);
      chk("full_s_ready", 37'(s_ready), 37'd0);
      chk("full_no_write", 37'(wr_cnt - w0), 37'd0);
      fork
         begin
            repeat (5) @(posedge wr_clk);
            #1 wr_vld = 1'b1;
         end
         begin
            for (int i = 8; i < 12; i++) send(8'h21 + 8'(i), i == 11);
         end
      join
      drain();
      chk("bp_stalled", 37'(stalls > 0), 37'd1);
      chk("bp_write_count", 37'(wr_cnt - w0), 37'd3);
      chk("frame_cnt_4", 37'(frame_cnt), 37'd4);

      // reset mid-frame with one word buffered
      wr_vld = 1'b0;
      for (int i = 0; i < 7; i++) send(8'h31 + 8'(i), 1'b0);
      @(posedge wr_clk); #1;
      wr_rst = 1'b1;
      @(negedge wr_clk);
      chk("midrst_s_ready", 37'(s_ready), 37'd0);
      chk("midrst_wr_en", 37'(wr_en), 37'd0);
      chk("midrst_head", {wr_last, wr_keep, wr_data}, 37'd0);
      chk("midrst_frame_cnt", 37'(frame_cnt), 37'd0);
      @(posedge wr_clk); #1;
      wr_rst = 1'b0;
      wr_vld = 1'b1;
      w0 = wr_cnt;
      repeat (3) @(negedge wr_clk);
      chk("midrst_no_write", 37'(wr_cnt - w0), 37'd0);
      @(posedge wr_clk); #1;
      push_exp(1'b1, 4'b1111, 32'h14131211);
      for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), i == 3);
      drain();
      chk("midrst_write_count", 37'(wr_cnt - w0), 37'd1);
      chk("frame_cnt_after_rst", 37'(frame_cnt), 37'd1);

      // frame counter wrap
      stalls = 0;
      for (int i = 0; i < 65535; i++) begin
         push_exp(1'b1, 4'b0001, {24'h0, 8'(i)});
         send(8'(i), 1'b1);
      end
      drain();
      chk("frame_cnt_wrap", 37'(frame_cnt), 37'd0);
      chk("wrap_no_stall", 37'(stalls), 37'd0);
      push_exp(1'b1, 4'b0001, 32'h0000005A);
      send(8'h5A, 1'b1);
      drain();
      chk("frame_cnt_post_wrap", 37'(frame_cnt), 37'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
